ucode_seq: RTL and testbench
============================

# ucode_seq

Parametrised micro-sequencer for the SM83 core: steps each decoded `ctl_op_t` through a variable-length list of `ex_state_t` M-cycle states. Supports:
- conditional early exit for branch instructions;
- memory-wait stalls;
- a HALT state with interrupt wake;
- an injected interrupt-dispatch sequence at instruction boundaries.

It sits between the instruction decoder and the strobe decoder `ex_decode`, which drives datapath enables.

## Interface
- `MAX_STEPS`, default 6: maximum M-cycles per instruction after fetch (≥2).
- `IRQ_STEPS`, default 5: length of the interrupt-dispatch sequence (≤`MAX_STEPS`).
- `IDX_W`, default `$clog2(MAX_STEPS)`: step index width.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `ctl_op`  in  `ctl_op_t`  decoded operation of the instruction in IR; stable for the whole instruction.
- `cond_met`  in  1  branch condition result from the flag check, valid every cycle.
- `mem_wait`  in  1  bus not ready; hold the current step.
- `ime`  in  1  interrupt master enable.
- `irq_pending`  in  1  any enabled interrupt flagged (IE & IF ≠ 0).
- `ex_state`  out  `ex_state_t`  current step state, fed to `ex_decode`.
- `step_idx`  out  `IDX_W`  current step index.
- `fetch`  out  1  last step: latch IR, increment PC.
- `cond_exit`  out  1  pulse: condition failed, instruction truncated.
- `halted`  out  1  core in HALT.
- `irq_ack`  out  1  one-cycle pulse on the first dispatch cycle (clears IF bit, IME).
- `in_irq`  out  1  dispatch sequence active.

## Operation
The table comes from `seq_lookup(ctl_op)` and returns `seq_t`:
- `steps[MAX_STEPS]`: step states.
- `last_idx`: index of the final step.
- `cond_idx`: step at which `cond_met` is sampled; sentinel all-ones means unconditional.

`ctl_op` values without an entry map to `{EX_IDLE…}`, `last_idx = 0`.

The FSM has three states: `RUN`, `HALT`, `IRQ`.

**RUN**
- `ex_state = steps[step_idx]`.
- `last = (step_idx == last_idx) | (step_idx == cond_idx & !cond_met)`.
- `cond_exit = last & step_idx == cond_idx & !cond_met`.
- Step state `EX_HALT`, not stalled → `HALT` next. No fetch that cycle, even if the step is last.
- Otherwise, on `last` with `!mem_wait`:
  - if `ime & irq_pending` → `IRQ`, `step_idx ← 0`, `fetch = 0`;
  - else `fetch = 1`, `step_idx ← 0`.
- Not last, `!mem_wait` → `step_idx + 1`.

**HALT**
- `ex_state = EX_IDLE`, `halted = 1`, `fetch = 0`, `step_idx` held at 0.
- On `irq_pending` (independent of `ime`):
  - `ime = 1` → `IRQ`;
  - `ime = 0` → `RUN`, with one `EX_IDLE` step carrying `fetch = 1`.
- `halted` deasserts the cycle after wake.

**IRQ**
- `in_irq = 1`. Steps are `EX_IDLE, EX_IDLE, EX_PUSH_PCH, EX_PUSH_PCL, EX_JP_VEC` (`IRQ_STEPS` entries).
- `irq_ack = 1` only at `step_idx == 0` with `!mem_wait`.
- At the final step, `fetch = 1` → `RUN`, index 0. No re-entry check at this boundary: the first vector instruction always executes.

**Stall**
- `mem_wait = 1` holds `step_idx` and state. `ex_state` is still presented.
- `fetch`, `irq_ack`, `cond_exit` and the `HALT` transition are gated to 0.
- `cond_met` is re-sampled each stalled cycle; the value in the releasing cycle decides.

**Boundary cases**
- `last_idx ≥ MAX_STEPS` from the table → treated as `MAX_STEPS-1`.
- `step_idx` never exceeds `MAX_STEPS-1`.
- A sequence with `cond_idx == last_idx` behaves as unconditional, but `cond_exit` still pulses on a false condition.
- An `irq_pending` that rises during a stalled last step is honoured on release.

## Timing
- Reset (`rst_n` low at a `clk` edge) values: state `RUN`, `step_idx = 0`, `halted = 0`. Applies mid-instruction or mid-dispatch; there is no partial completion.
- Out of reset, `ctl_op` is `CTL_NOP`, so the first cycle is `EX_IDLE` with `fetch = 1`.
- Outputs other than `halted` and `in_irq` are combinational from state, `step_idx`, `ctl_op` and the inputs.
- Latency:
  - An instruction with `last_idx = N` takes N+1 cycles, fetch included, absent stalls.
  - A condition failure at `cond_idx = k` takes k+1 cycles.
  - HALT wake to IRQ first cycle is 1 clock.

## Structure
The following belong in `sm83_pkg`:
- `seq_t`;
- `seq_lookup()` function;
- `MAX_STEPS_DEF` and `COND_NONE` constants;
- the new `ex_state_t` members `EX_PUSH_PCH`, `EX_PUSH_PCL`, `EX_JP_VEC`, `EX_COND_CHK`;
- `seq_state_t` (`RUN`, `HALT`, `IRQ`).

Sub-module: `ex_decode`, combinational, mapping `ex_state_t` + `ctl_op` + `fetch` to datapath strobes. It is instantiated beside `ucode_seq`, not inside it.

## Test plan
1. `CTL_LDPTR_A_A16` (`last_idx = 3`), no stall → `ex_state` runs `MEM_TO_Z, MEM_TO_W, MEM_WZ_TO_Z, ALU_LD1`; `fetch` high only in cycle 4.
2. JR cc (`cond_idx = 1`, `last_idx = 2`):
   - `cond_met = 0` → `cond_exit` and `fetch` in cycle 2;
   - `cond_met = 1` → `fetch` in cycle 3, no `cond_exit`.
3. `mem_wait` high for 3 cycles at step 1 of `CTL_LD_R8_D8` → `step_idx` held at 1, `fetch` suppressed, instruction completes 3 cycles late.
4. `CTL_HALT`, then `irq_pending` after 10 cycles:
   - `ime = 1` → `halted` drops, `irq_ack` pulses once, 5 dispatch steps, `fetch` on step 4;
   - `ime = 0` → a single `fetch` cycle.
5. `ime = 1`, `irq_pending` asserted during the last step of `CTL_ALU_R8` → no `fetch`, IRQ sequence entered next cycle.
6. Reset asserted at IRQ step 2 → next cycle `RUN`, `step_idx = 0`, `in_irq = 0`, `fetch = 1` for `CTL_NOP`.

Source files
------------

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared decode/sequencer types and the per-op M-cycle step table
package sm83_pkg;
  localparam int MAX_STEPS_DEF = 6;
  localparam int SEQ_IDX_W = 3;
  localparam logic [SEQ_IDX_W-1:0] COND_NONE = '1;
  typedef enum logic [4:0] {
    CTL_NOP, CTL_LDPTR_A_A16, CTL_JR_CC, CTL_LD_R8_D8, CTL_HALT,
    CTL_ALU_R8, CTL_CALL_CC, CTL_COND_LAST, CTL_LONG, CTL_ILLEGAL
  } ctl_op_t;
  typedef enum logic [3:0] {
    EX_IDLE, EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_LD1, EX_ALU_OP,
    EX_HALT, EX_ADD_PC_Z, EX_JP_WZ, EX_PUSH_PCH, EX_PUSH_PCL, EX_JP_VEC, EX_COND_CHK
  } ex_state_t;
  typedef enum logic [1:0] {RUN, HALT, IRQ} seq_state_t;
  typedef struct packed {
    ex_state_t [MAX_STEPS_DEF-1:0] steps;
    logic [SEQ_IDX_W-1:0] last_idx;
    logic [SEQ_IDX_W-1:0] cond_idx;
  } seq_t;
  function automatic seq_t seq_lookup(input ctl_op_t op);
    seq_t s;
    s = '0;
    s.cond_idx = COND_NONE;
    case (op)
      CTL_LDPTR_A_A16: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_MEM_TO_W;
        s.steps[2] = EX_MEM_WZ_TO_Z;
        s.steps[3] = EX_ALU_LD1;
        s.last_idx = 3'd3;
      end
      CTL_JR_CC: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_COND_CHK;
        s.steps[2] = EX_ADD_PC_Z;
        s.last_idx = 3'd2;
        s.cond_idx = 3'd1;
      end
      CTL_LD_R8_D8: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_ALU_LD1;
        s.last_idx = 3'd1;
      end
      CTL_HALT: s.steps[0] = EX_HALT;
      CTL_ALU_R8: s.steps[0] = EX_ALU_OP;
      CTL_CALL_CC: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_MEM_TO_W;
        s.steps[2] = EX_COND_CHK;
        s.steps[3] = EX_PUSH_PCH;
        s.steps[4] = EX_PUSH_PCL;
        s.steps[5] = EX_JP_WZ;
        s.last_idx = 3'd5;
        s.cond_idx = 3'd2;
      end
      CTL_COND_LAST: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_COND_CHK;
        s.last_idx = 3'd1;
        s.cond_idx = 3'd1;
      end
      CTL_LONG: begin
        s.steps[0] = EX_MEM_TO_Z;
        s.steps[1] = EX_MEM_TO_W;
        s.steps[2] = EX_ALU_OP;
        s.steps[3] = EX_ALU_OP;
        s.steps[4] = EX_ALU_OP;
        s.steps[5] = EX_ALU_LD1;
        s.last_idx = 3'd7;
      end
      default: ;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/ucode_seq.sv
// ucode_seq: steps each decoded op through its M-cycle list, with branch exit,
// memory stalls, HALT with interrupt wake and boundary interrupt dispatch
module ucode_seq
  import sm83_pkg::*;
#(
  parameter int MAX_STEPS = MAX_STEPS_DEF,
  parameter int IRQ_STEPS = 5,
  parameter int IDX_W = $clog2(MAX_STEPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ctl_op_t          ctl_op,
  input  logic             cond_met,
  input  logic             mem_wait,
  input  logic             ime,
  input  logic             irq_pending,
  output ex_state_t        ex_state,
  output logic [IDX_W-1:0] step_idx,
  output logic             fetch,
  output logic             cond_exit,
  output logic             halted,
  output logic             irq_ack,
  output logic             in_irq
);
  seq_state_t r_state, w_nstate;
  logic [IDX_W-1:0] r_idx, w_nidx;
  logic r_wake, w_nwake;
  seq_t w_seq;
  int w_lim;
  ex_state_t w_step, w_irq_step;
  logic w_cfail, w_last, w_to_halt, w_bound, w_dispatch, w_irq_end;
  always_comb begin
    w_seq = seq_lookup(ctl_op);
    w_lim = int'(w_seq.last_idx) > MAX_STEPS - 1 ? MAX_STEPS - 1 : int'(w_seq.last_idx);
    w_cfail = !r_wake && w_seq.cond_idx != COND_NONE && int'(r_idx) == int'(w_seq.cond_idx) && !cond_met;
    // r_wake is the single idle fetch step after a HALT wake with interrupts masked
    w_last = r_wake || int'(r_idx) >= w_lim || w_cfail;
    w_step = r_wake ? EX_IDLE : w_seq.steps[r_idx];
    w_irq_step = int'(r_idx) == IRQ_STEPS - 1 ? EX_JP_VEC :
                 int'(r_idx) == IRQ_STEPS - 2 ? EX_PUSH_PCL :
                 int'(r_idx) == IRQ_STEPS - 3 ? EX_PUSH_PCH : EX_IDLE;
    w_to_halt = r_state == RUN && w_step == EX_HALT && !mem_wait;
    w_bound = r_state == RUN && w_last && !mem_wait && !w_to_halt;
    w_dispatch = w_bound && ime && irq_pending;
    w_irq_end = r_state == IRQ && int'(r_idx) == IRQ_STEPS - 1 && !mem_wait;
    w_nstate = w_to_halt ? HALT :
               w_dispatch ? IRQ :
               w_irq_end ? RUN :
               r_state == HALT && irq_pending ? (ime ? IRQ : RUN) : r_state;
    w_nidx = (w_to_halt || w_bound || w_irq_end || r_state == HALT) ? '0 :
             mem_wait ? r_idx : r_idx + IDX_W'(1);
    w_nwake = r_state == HALT ? irq_pending && !ime : r_wake && mem_wait;
    ex_state = r_state == RUN ? w_step : r_state == IRQ ? w_irq_step : EX_IDLE;
    step_idx = r_idx;
    fetch = (w_bound && !w_dispatch) || w_irq_end;
    cond_exit = r_state == RUN && w_cfail && !mem_wait;
    irq_ack = r_state == IRQ && r_idx == '0 && !mem_wait;
    halted = r_state == HALT;
    in_irq = r_state == IRQ;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_idx <= '0;
      r_wake <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_idx <= w_nidx;
      r_wake <= w_nwake;
    end
  end
endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed test-plan scenarios plus randomized traffic against a step-list reference model
module tb_ucode_seq;
  import sm83_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  ctl_op_t ctl_op = CTL_NOP;
  logic cond_met = 1'b0, mem_wait = 1'b0, ime = 1'b0, irq_pending = 1'b0;
  ex_state_t ex_state;
  logic [2:0] step_idx;
  logic fetch, cond_exit, halted, irq_ack, in_irq;
  int n_chk = 0, n_err = 0;
  int m_mode = 0, m_pos = 0;
  bit m_wake = 0;
  ex_state_t e_es;
  bit e_fetch, e_cexit, e_halted, e_ack, e_in_irq, e_halt_go, e_bnd, e_disp;
  ex_state_t s_es;
  logic s_fetch, s_cexit, s_halted, s_ack, s_in_irq;
  logic [2:0] s_idx;
  ex_state_t irq_seq [5] = '{EX_IDLE, EX_IDLE, EX_PUSH_PCH, EX_PUSH_PCL, EX_JP_VEC};
  ctl_op_t ops [10] = '{CTL_NOP, CTL_LDPTR_A_A16, CTL_JR_CC, CTL_LD_R8_D8, CTL_HALT,
                        CTL_ALU_R8, CTL_CALL_CC, CTL_COND_LAST, CTL_LONG, CTL_ILLEGAL};
  always #5 clk = ~clk;
  ucode_seq dut (
    .clk(clk), .rst_n(rst_n), .ctl_op(ctl_op), .cond_met(cond_met), .mem_wait(mem_wait),
    .ime(ime), .irq_pending(irq_pending), .ex_state(ex_state), .step_idx(step_idx),
    .fetch(fetch), .cond_exit(cond_exit), .halted(halted), .irq_ack(irq_ack), .in_irq(in_irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ex_state_t tb_step(input ctl_op_t op, input int i);
    ex_state_t l [6];
    l = '{default: EX_IDLE};
    case (op)
      CTL_LDPTR_A_A16: l = '{EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_LD1, EX_IDLE, EX_IDLE};
      CTL_JR_CC:       l = '{EX_MEM_TO_Z, EX_COND_CHK, EX_ADD_PC_Z, EX_IDLE, EX_IDLE, EX_IDLE};
      CTL_LD_R8_D8:    l = '{EX_MEM_TO_Z, EX_ALU_LD1, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
      CTL_HALT:        l[0] = EX_HALT;
      CTL_ALU_R8:      l[0] = EX_ALU_OP;
      CTL_CALL_CC:     l = '{EX_MEM_TO_Z, EX_MEM_TO_W, EX_COND_CHK, EX_PUSH_PCH, EX_PUSH_PCL, EX_JP_WZ};
      CTL_COND_LAST:   l = '{EX_MEM_TO_Z, EX_COND_CHK, EX_IDLE, EX_IDLE, EX_IDLE, EX_IDLE};
      CTL_LONG:        l = '{EX_MEM_TO_Z, EX_MEM_TO_W, EX_ALU_OP, EX_ALU_OP, EX_ALU_OP, EX_ALU_LD1};
      default: ;
    endcase
    return l[i];
  endfunction
  function automatic int tb_last(input ctl_op_t op);
    int raw;
    case (op)
      CTL_LDPTR_A_A16: raw = 3;
      CTL_JR_CC: raw = 2;
      CTL_LD_R8_D8, CTL_COND_LAST: raw = 1;
      CTL_CALL_CC: raw = 5;
      CTL_LONG: raw = 7;
      default: raw = 0;
    endcase
    return raw > 5 ? 5 : raw;
  endfunction
  function automatic int tb_cond(input ctl_op_t op);
    case (op)
      CTL_JR_CC, CTL_COND_LAST: return 1;
      CTL_CALL_CC: return 2;
      default: return -1;
    endcase
  endfunction
  task automatic model_eval();
    bit fail, lastc;
    e_es = EX_IDLE; e_fetch = 0; e_cexit = 0; e_halted = 0; e_ack = 0; e_in_irq = 0;
    e_halt_go = 0; e_bnd = 0; e_disp = 0;
    if (m_mode == 0) begin
      fail = !m_wake && tb_cond(ctl_op) == m_pos && !cond_met;
      lastc = m_wake || m_pos == tb_last(ctl_op) || fail;
      e_es = m_wake ? EX_IDLE : tb_step(ctl_op, m_pos);
      e_halt_go = e_es == EX_HALT && !mem_wait;
      e_bnd = lastc && !mem_wait && !e_halt_go;
      e_disp = e_bnd && ime && irq_pending;
      e_fetch = e_bnd && !e_disp;
      e_cexit = fail && !mem_wait;
    end else if (m_mode == 1) e_halted = 1;
    else begin
      e_in_irq = 1;
      e_es = irq_seq[m_pos];
      e_ack = m_pos == 0 && !mem_wait;
      e_fetch = m_pos == 4 && !mem_wait;
    end
  endtask
  task automatic model_step();
    if (m_mode == 0) begin
      if (e_halt_go) begin m_mode = 1; m_pos = 0; m_wake = 0; end
      else if (e_bnd) begin m_mode = e_disp ? 2 : 0; m_pos = 0; m_wake = 0; end
      else if (!mem_wait) m_pos++;
    end else if (m_mode == 1) begin
      if (irq_pending) begin m_mode = ime ? 2 : 0; m_wake = !ime; end
    end else if (!mem_wait) begin
      if (m_pos == 4) begin m_mode = 0; m_pos = 0; end
      else m_pos++;
    end
  endtask
  task automatic cyc(input ctl_op_t op, input bit cm, input bit mw, input bit ie, input bit ip, input bit rs);
    ctl_op = op; cond_met = cm; mem_wait = mw; ime = ie; irq_pending = ip; rst_n = !rs;
    @(negedge clk);
    s_es = ex_state; s_idx = step_idx; s_fetch = fetch; s_cexit = cond_exit;
    s_halted = halted; s_ack = irq_ack; s_in_irq = in_irq;
    if (rs) begin
      m_mode = 0; m_pos = 0; m_wake = 0;
    end else begin
      model_eval();
      chk("ex_state", 32'(s_es), 32'(e_es));
      chk("step_idx", 32'(s_idx), 32'(m_pos));
      chk("fetch", 32'(s_fetch), 32'(e_fetch));
      chk("cond_exit", 32'(s_cexit), 32'(e_cexit));
      chk("halted", 32'(s_halted), 32'(e_halted));
      chk("irq_ack", 32'(s_ack), 32'(e_ack));
      chk("in_irq", 32'(s_in_irq), 32'(e_in_irq));
      model_step();
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] fv, cv;
    int acks;
    ctl_op_t cur;
    bit rs;
    ex_state_t t1 [4] = '{EX_MEM_TO_Z, EX_MEM_TO_W, EX_MEM_WZ_TO_Z, EX_ALU_LD1};
    cyc(CTL_NOP, 0, 0, 0, 0, 1);
    cyc(CTL_NOP, 0, 0, 0, 0, 1);
    cyc(CTL_NOP, 0, 0, 0, 0, 0);
    chk("rst_fetch", 32'(s_fetch), 32'd1);
    chk("rst_es", 32'(s_es), 32'(EX_IDLE));
    chk("rst_idx", 32'(s_idx), 32'd0);
    chk("rst_halted", 32'(s_halted), 32'd0);
    fv = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(CTL_LDPTR_A_A16, 0, 0, 0, 0, 0);
      fv[i] = s_fetch;
      chk($sformatf("t1_es%0d", i), 32'(s_es), 32'(t1[i]));
    end
    chk("t1_fetch", 32'(fv), 32'h08);
    fv = '0; cv = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(CTL_JR_CC, 0, 0, 0, 0, 0);
      fv[i] = s_fetch; cv[i] = s_cexit;
    end
    chk("t2_nt_fetch", 32'(fv), 32'h02);
    chk("t2_nt_cexit", 32'(cv), 32'h02);
    fv = '0; cv = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(CTL_JR_CC, 1, 0, 0, 0, 0);
      fv[i] = s_fetch; cv[i] = s_cexit;
    end
    chk("t2_tk_fetch", 32'(fv), 32'h04);
    chk("t2_tk_cexit", 32'(cv), 32'h00);
    fv = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(CTL_LD_R8_D8, 0, i >= 1 && i <= 3, 0, 0, 0);
      fv[i] = s_fetch;
      if (i > 0) chk($sformatf("t3_idx%0d", i), 32'(s_idx), 32'd1);
    end
    chk("t3_fetch", 32'(fv), 32'h10);
    cyc(CTL_HALT, 0, 0, 1, 0, 0);
    chk("t4_halt_nofetch", 32'(s_fetch), 32'd0);
    for (int i = 0; i < 10; i++) cyc(CTL_HALT, 0, 0, 1, 0, 0);
    chk("t4_halted", 32'(s_halted), 32'd1);
    cyc(CTL_HALT, 0, 0, 1, 1, 0);
    fv = '0; acks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(CTL_HALT, 0, 0, 0, 0, 0);
      fv[i] = s_fetch;
      acks += int'(s_ack);
      if (i == 0) chk("t4_wake_halted", 32'(s_halted), 32'd0);
      chk($sformatf("t4_in_irq%0d", i), 32'(s_in_irq), 32'd1);
    end
    chk("t4_acks", 32'(acks), 32'd1);
    chk("t4_irq_fetch", 32'(fv), 32'h10);
    cyc(CTL_NOP, 0, 0, 0, 0, 0);
    cyc(CTL_HALT, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(CTL_HALT, 0, 0, 0, 0, 0);
    cyc(CTL_HALT, 0, 0, 0, 1, 0);
    cyc(CTL_HALT, 0, 0, 0, 0, 0);
    chk("t4b_fetch", 32'(s_fetch), 32'd1);
    chk("t4b_es", 32'(s_es), 32'(EX_IDLE));
    chk("t4b_halted", 32'(s_halted), 32'd0);
    cyc(CTL_ALU_R8, 0, 0, 1, 1, 0);
    chk("t5_nofetch", 32'(s_fetch), 32'd0);
    cyc(CTL_ALU_R8, 0, 0, 0, 0, 0);
    chk("t5_in_irq", 32'(s_in_irq), 32'd1);
    chk("t5_ack", 32'(s_ack), 32'd1);
    for (int i = 0; i < 4; i++) cyc(CTL_ALU_R8, 0, 0, 0, 0, 0);
    cyc(CTL_ALU_R8, 0, 1, 1, 0, 0);
    cyc(CTL_ALU_R8, 0, 1, 1, 1, 0);
    chk("stall_irq_nofetch", 32'(s_fetch), 32'd0);
    cyc(CTL_ALU_R8, 0, 0, 1, 1, 0);
    chk("rel_irq_nofetch", 32'(s_fetch), 32'd0);
    cyc(CTL_ALU_R8, 0, 0, 0, 0, 0);
    chk("rel_irq_in_irq", 32'(s_in_irq), 32'd1);
    for (int i = 0; i < 4; i++) cyc(CTL_ALU_R8, 0, 0, 0, 0, 0);
    cyc(CTL_NOP, 0, 0, 1, 1, 0);
    cyc(CTL_NOP, 0, 0, 0, 0, 0);
    cyc(CTL_NOP, 0, 0, 0, 0, 0);
    cyc(CTL_NOP, 0, 0, 0, 0, 1);
    cyc(CTL_NOP, 0, 0, 0, 0, 0);
    chk("t6_in_irq", 32'(s_in_irq), 32'd0);
    chk("t6_idx", 32'(s_idx), 32'd0);
    chk("t6_fetch", 32'(s_fetch), 32'd1);
    fv = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(CTL_LONG, 0, 0, 0, 0, 0);
      fv[i] = s_fetch;
    end
    chk("long_fetch", 32'(fv), 32'h20);
    chk("long_idx", 32'(s_idx), 32'd5);
    fv = '0; cv = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(CTL_COND_LAST, 0, 0, 0, 0, 0);
      fv[i] = s_fetch; cv[i] = s_cexit;
    end
    chk("clast_fetch", 32'(fv), 32'h02);
    chk("clast_cexit", 32'(cv), 32'h02);
    cyc(CTL_ILLEGAL, 0, 0, 0, 0, 0);
    chk("illegal_fetch", 32'(s_fetch), 32'd1);
    chk("illegal_es", 32'(s_es), 32'(EX_IDLE));
    cur = CTL_NOP;
    for (int n = 0; n < 3000; n++) begin
      rs = $urandom_range(0, 299) == 0;
      cyc(cur, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, rs);
      if (rs) cur = CTL_NOP;
      else if (s_fetch) cur = ops[$urandom_range(0, 9)];
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
